line_buffer_pingpong: RTL

//  Double-banked (ping-pong) line buffer between the pixel source and the display streamer.
//  - Writer fills one bank with one full line while the reader drains the other bank.
//  - Both sides use valid/ready handshakes; banks swap automatically.
//  - Generalises the single-line RAM: parametrised width/depth, two banks, flow control.

---
 rtl/line_buffer_pingpong_if.sv | 31 +++
 rtl/line_buffer_pingpong.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_pingpong_if.sv
// Handshake bundle for line_buffer_pingpong: pixel source side (write),
// display streamer side (read), flush and occupancy status.
// The buffer itself connects through the slave modport; whoever drives the
// source/sink side uses the master modport.
interface line_buffer_pingpong_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  flush;
  logic                  writeValid;
  logic                  writeReady;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  writeLineDone;
  logic                  readValid;
  logic                  readReady;
  logic [DATA_WIDTH-1:0] readData;
  logic                  readFirst;
  logic                  readLast;
  logic [1:0]            linesBuffered;

  modport slave (
    input  flush, writeValid, writeData, readReady,
    output writeReady, writeLineDone, readValid, readData, readFirst, readLast,
           linesBuffered
  );

  modport master (
    output flush, writeValid, writeData, readReady,
    input  writeReady, writeLineDone, readValid, readData, readFirst, readLast,
           linesBuffered
  );
endinterface

// File: rtl/line_buffer_pingpong.sv
// Ping-pong line buffer: the writer fills one bank with a full line while the
// reader drains the other. Each bank walks EMPTY -> FILLING -> FULL ->
// DRAINING -> EMPTY. The read side uses a synchronous RAM read followed by a
// 2-entry skid FIFO so it sustains one pixel per clock under arbitrary
// readReady stalls without losing or repeating pixels.
//
// Optional build macro SCALE2X_EN: every stored pixel is emitted twice on the
// read side (2x horizontal upscale), giving 2*LINE_PIXELS transfers per line.
module line_buffer_pingpong #(
  parameter int DATA_WIDTH  = 16,
  parameter int LINE_PIXELS = 480,
  parameter int ADDR_WIDTH  = 9
) (
  input logic                   clock,
  input logic                   reset,
  line_buffer_pingpong_if.slave bus
);

`ifdef SCALE2X_EN
  localparam logic SCALE2X = 1'b1;
`else
  localparam logic SCALE2X = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LINE_PIXELS - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // A bank counts towards linesBuffered once it holds a complete line.
  function automatic logic [1:0] holds_line(input bank_state_t s);
    return ((s == FULL) || (s == DRAINING)) ? 2'd1 : 2'd0;
  endfunction

  // Both banks share one array; the bank index is the top address bit.
  logic [DATA_WIDTH-1:0] mem [0:(2**(ADDR_WIDTH+1))-1];

  bank_state_t           bank_st [0:1];

  // Write side
  logic                  wr_bank;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  done_q;

  // Read address issue side; iss_rep is the copy index in 2x mode
  logic                  iss_bank;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic                  iss_rep;
  logic                  iss_mid;

  // Bank whose last pixel the consumer is still waiting for
  logic                  rel_bank;

  // RAM output stage
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  first_p1;
  logic                  last_p1;

  // Output skid FIFO
  logic [DATA_WIDTH-1:0] fifo_data  [0:1];
  logic                  fifo_first [0:1];
  logic                  fifo_last  [0:1];
  logic                  fifo_wp;
  logic                  fifo_rp;
  logic [1:0]            fifo_cnt;

  logic                  clr;
  logic                  write_ready;
  logic                  wr_fire;
  logic                  wr_end;
  logic                  read_valid;
  logic                  pop;
  logic                  pop_last;
  logic                  iss_avail;
  logic [2:0]            occ_after_pop;
  logic                  issue;
  logic                  iss_first;
  logic                  iss_last;

  // Flush behaves exactly like reset and overrides any handshake this cycle.
  assign clr = reset | bus.flush;

  assign write_ready = ~clr & ((bank_st[wr_bank] == EMPTY) || (bank_st[wr_bank] == FILLING));
  assign wr_fire     = bus.writeValid & write_ready;
  assign wr_end      = wr_fire & (wr_addr == LAST_ADDR);

  assign read_valid  = ~clr & (fifo_cnt != 2'd0);
  assign pop         = read_valid & bus.readReady;
  assign pop_last    = pop & fifo_last[fifo_rp];

  // The reader only starts a bank once it is FULL, then keeps issuing until
  // the whole line (including duplicates in 2x mode) is in flight.
  assign iss_avail     = iss_mid || (bank_st[iss_bank] == FULL);
  // Entries held after this cycle: FIFO plus the RAM read in flight, minus a pop.
  assign occ_after_pop = 3'(fifo_cnt) + 3'(vld_p1) - 3'(pop);
  assign issue         = ~clr & iss_avail & (occ_after_pop < 3'd2);
  assign iss_first     = (iss_addr == '0) & ~iss_rep;
  assign iss_last      = (iss_addr == LAST_ADDR) & (iss_rep == SCALE2X);

  // Bank state machine plus write/issue/release pointers and FIFO control.
  always_ff @(posedge clock) begin
    if (clr) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      done_q     <= 1'b0;
      iss_bank   <= 1'b0;
      iss_addr   <= '0;
      iss_rep    <= 1'b0;
      iss_mid    <= 1'b0;
      rel_bank   <= 1'b0;
      vld_p1     <= 1'b0;
      fifo_wp    <= 1'b0;
      fifo_rp    <= 1'b0;
      fifo_cnt   <= 2'd0;
    end else begin
      done_q <= wr_end;

      if (wr_fire) begin
        if (wr_end) begin
          wr_addr          <= '0;
          bank_st[wr_bank] <= FULL;
          wr_bank          <= ~wr_bank;
        end else begin
          wr_addr          <= wr_addr + 1'b1;
          bank_st[wr_bank] <= FILLING;
        end
      end

      vld_p1 <= issue;
      if (issue) begin
        if (!iss_mid) begin
          bank_st[iss_bank] <= DRAINING;
        end
        if (iss_last) begin
          iss_mid  <= 1'b0;
          iss_addr <= '0;
          iss_rep  <= 1'b0;
          iss_bank <= ~iss_bank;
        end else begin
          iss_mid <= 1'b1;
          if (iss_rep == SCALE2X) begin
            iss_addr <= iss_addr + 1'b1;
            iss_rep  <= 1'b0;
          end else begin
            iss_rep  <= 1'b1;
          end
        end
      end

      // A bank is handed back to the writer once its last pixel is consumed.
      if (pop_last) begin
        bank_st[rel_bank] <= EMPTY;
        rel_bank          <= ~rel_bank;
      end

      if (vld_p1) begin
        fifo_wp <= ~fifo_wp;
      end
      if (pop) begin
        fifo_rp <= ~fifo_rp;
      end
      if (vld_p1 && !pop) begin
        fifo_cnt <= fifo_cnt + 2'd1;
      end else if (!vld_p1 && pop) begin
        fifo_cnt <= fifo_cnt - 2'd1;
      end
    end
  end

  // Stage p0 -> RAM write port: store accepted pixels into the write bank.
  always_ff @(posedge clock) begin
    if (wr_fire) begin
      mem[{wr_bank, wr_addr}] <= bus.writeData;
    end
  end

  // Stage p0 -> p1: synchronous RAM read with line-position tags.
  always_ff @(posedge clock) begin
    if (issue) begin
      data_p1  <= mem[{iss_bank, iss_addr}];
      first_p1 <= iss_first;
      last_p1  <= iss_last;
    end
  end

  // Stage p1 -> skid FIFO: capture the RAM output the cycle it arrives.
  always_ff @(posedge clock) begin
    if (vld_p1) begin
      fifo_data[fifo_wp]  <= data_p1;
      fifo_first[fifo_wp] <= first_p1;
      fifo_last[fifo_wp]  <= last_p1;
    end
  end

  assign bus.writeReady    = write_ready;
  assign bus.writeLineDone = done_q;
  assign bus.readValid     = read_valid;
  assign bus.readData      = read_valid ? fifo_data[fifo_rp] : '0;
  assign bus.readFirst     = read_valid & fifo_first[fifo_rp];
  assign bus.readLast      = read_valid & fifo_last[fifo_rp];
  assign bus.linesBuffered = holds_line(bank_st[0]) + holds_line(bank_st[1]);

endmodule
